cosine_vec_loader: RTL and testbench
====================================

COSINE_VEC_LOADER -- requirements
Module: cosine_vec_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before abort.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-003 SHALL have port in_valid input 1: upstream element byte valid.
REQ-004 SHALL have port in_data input 8: element byte, unsigned.
REQ-005 SHALL have port in_ready output 1: loader accepts a byte this cycle.
REQ-006 SHALL have port core_rst_n output 1: active-low reset to the cosine core.
REQ-007 SHALL have port core_start output 1: single-cycle start pulse to the core.
REQ-008 SHALL have ports core_a_vec and core_b_vec, output 32 each: packed vectors, element k in bits [8k+7:8k].
REQ-009 SHALL have port core_done input 1: core completion flag, sticky until core reset.
REQ-010 SHALL have port core_cos input 16: core cosine result.
REQ-011 SHALL have port res_valid output 1: result available.
REQ-012 SHALL have port res_data output 16: captured result.
REQ-013 SHALL have port res_timeout output 1: result aborted by timeout.
REQ-014 SHALL have port res_ready input 1: downstream accepts result.
REQ-015 SHALL have port busy output 1: high in every state except LOAD_A with zero bytes held.

Function
REQ-016 SHALL implement states LOAD_A, LOAD_B, CORE_RST, START, WAIT, RESULT.
REQ-017 SHALL drive in_ready=1 only in LOAD_A/LOAD_B; a byte transfers when in_valid&&in_ready.
REQ-018 SHALL write A byte k (k=0..3, arrival order) to core_a_vec[8k+7:8k]; after byte 3 move to LOAD_B with the 2-bit index wrapped to 0.
REQ-019 SHALL load B the same way into core_b_vec; after byte 3 move to CORE_RST.
REQ-020 SHALL hold core_rst_n=0 for exactly one cycle in CORE_RST, then move to START; core_rst_n=1 in all other states when reset is low.
REQ-021 SHALL assert core_start=1 for exactly the one START cycle, clear the timeout counter, then move to WAIT.
REQ-022 SHALL ignore core_done in every state except WAIT.
REQ-023 In WAIT, the first cycle with core_done=1 SHALL capture core_cos into res_data, clear res_timeout and move to RESULT.
REQ-024 In WAIT, the counter SHALL increment each cycle without done; when it reaches TIMEOUT_CYCLES it SHALL set res_data=0, set res_timeout=1 and move to RESULT.
REQ-025 When done and the timeout occur in the same cycle, done SHALL win: res_timeout=0 and core_cos is captured.
REQ-026 The counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate, never wrap.
REQ-027 In RESULT, res_valid SHALL be 1 and res_data/res_timeout stable until res_valid&&res_ready; then move to LOAD_A, with in_ready=1 on the next cycle.
REQ-028 core_a_vec/core_b_vec SHALL be stable from CORE_RST entry through RESULT exit, and SHALL keep their values (not clear) on return to LOAD_A.
REQ-029 res_valid SHALL rise the cycle after capture; res_data SHALL be registered output.

Reset
REQ-030 While reset=1, core_rst_n SHALL be driven 0.
REQ-031 On reset, the state SHALL go to LOAD_A and all outputs and registers SHALL clear: in_ready=0 during reset, then 1; core_start=0; vectors=0; res_valid=0; res_data=0; res_timeout=0; byte index=0; counter=0.
REQ-032 Reset at any point, including mid-load or in WAIT, SHALL abort the operation and discard partial bytes; no result is produced.

Structure
REQ-033 Shared package cosine_pkg SHALL hold the state enum loader_state_t and the constants ELEM_W=8, N_ELEMS=4 and RES_W=16.
REQ-034 The block SHALL contain no sub-module; it is a single FSM with packing registers and a timeout counter.

Verification
REQ-035 Bytes 01,02,03,04 then 05,06,07,08 -> core_a_vec=0x04030201, core_b_vec=0x08070605; core_rst_n low 1 cycle, then core_start high 1 cycle.
REQ-036 core_done rises with core_cos=0x0007, res_ready=1 -> res_valid the next cycle, res_data=0x0007, res_timeout=0, in_ready=1 after the handshake.
REQ-037 core_done tied 0 -> exactly 64 WAIT cycles, then res_valid=1, res_data=0, res_timeout=1.
REQ-038 core_done rises on WAIT cycle 64 -> res_timeout=0 and res_data=core_cos.
REQ-039 res_ready held 0 for 10 cycles in RESULT -> res_data stable, in_ready=0, upstream bytes not consumed.
REQ-040 reset pulse after 2 B bytes -> next cycle LOAD_A, vectors=0, core_rst_n=1; a fresh 8-byte load completes normally.

Source files
------------

// File: rtl/cosine_pkg.sv
// Shared types and sizing constants for the cosine vector loader.
package cosine_pkg;

  localparam int ELEM_W  = 8;
  localparam int N_ELEMS = 4;
  localparam int RES_W   = 16;
  localparam int IDX_W   = $clog2(N_ELEMS);
  localparam int VEC_W   = ELEM_W * N_ELEMS;

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    CORE_RST = 3'd2,
    START    = 3'd3,
    WAIT     = 3'd4,
    RESULT   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/cosine_vec_loader.sv
// Packs two 4-byte vectors from a byte stream, resets and starts the cosine
// core, then returns its result (or a timeout marker) over a valid/ready port.
module cosine_vec_loader
  import cosine_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ELEM_W-1:0]  in_data,
  output logic               in_ready,
  output logic               core_rst_n,
  output logic               core_start,
  output logic [VEC_W-1:0]   core_a_vec,
  output logic [VEC_W-1:0]   core_b_vec,
  input  logic               core_done,
  input  logic [RES_W-1:0]   core_cos,
  output logic               res_valid,
  output logic [RES_W-1:0]   res_data,
  output logic               res_timeout,
  input  logic               res_ready,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  loader_state_t     state_r;
  loader_state_t     state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [VEC_W-1:0]  a_vec_r;
  logic [VEC_W-1:0]  b_vec_r;
  logic [RES_W-1:0]  res_data_r;
  logic              res_timeout_r;
  logic              in_ready_s;
  logic              xfer_s;
  logic              done_hit_s;
  logic              tmo_hit_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    xfer_s      = 1'b0;
    done_hit_s  = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      LOAD_A: begin
        in_ready_s = ~reset;
        xfer_s     = in_valid & ~reset;
        if (xfer_s && (idx_r == IDX_W'(N_ELEMS - 1))) begin
          state_nxt_s = LOAD_B;
        end else begin
          state_nxt_s = LOAD_A;
        end
      end
      LOAD_B: begin
        in_ready_s = ~reset;
        xfer_s     = in_valid & ~reset;
        if (xfer_s && (idx_r == IDX_W'(N_ELEMS - 1))) begin
          state_nxt_s = CORE_RST;
        end else begin
          state_nxt_s = LOAD_B;
        end
      end
      CORE_RST: state_nxt_s = START;
      START:    state_nxt_s = WAIT;
      WAIT: begin
        // done has priority over a timeout landing on the same cycle
        if (core_done) begin
          done_hit_s  = 1'b1;
          state_nxt_s = RESULT;
        end else if (cnt_r >= CNT_LAST) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = RESULT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_nxt_s = LOAD_A;
        end else begin
          state_nxt_s = RESULT;
        end
      end
      default: state_nxt_s = LOAD_A;
    endcase
  end

  // Packing registers, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r         <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      a_vec_r       <= {VEC_W{1'b0}};
      b_vec_r       <= {VEC_W{1'b0}};
      res_data_r    <= {RES_W{1'b0}};
      res_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A: begin
          if (xfer_s) begin
            a_vec_r[idx_r*ELEM_W +: ELEM_W] <= in_data;
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        LOAD_B: begin
          if (xfer_s) begin
            b_vec_r[idx_r*ELEM_W +: ELEM_W] <= in_data;
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        START: cnt_r <= {CNT_W{1'b0}};
        WAIT: begin
          if (done_hit_s) begin
            res_data_r    <= core_cos;
            res_timeout_r <= 1'b0;
          end else if (tmo_hit_s) begin
            res_data_r    <= {RES_W{1'b0}};
            res_timeout_r <= 1'b1;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign core_rst_n  = ~reset & (state_r != CORE_RST);
  assign core_start  = ~reset & (state_r == START);
  assign res_valid   = ~reset & (state_r == RESULT);
  assign busy        = ~((state_r == LOAD_A) && (idx_r == {IDX_W{1'b0}}));
  assign core_a_vec  = a_vec_r;
  assign core_b_vec  = b_vec_r;
  assign res_data    = res_data_r;
  assign res_timeout = res_timeout_r;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Directed self-checking bench for cosine_vec_loader.
module tb_cosine_vec_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        core_rst_n;
  logic        core_start;
  logic [31:0] core_a_vec;
  logic [31:0] core_b_vec;
  logic        core_done;
  logic [15:0] core_cos;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_timeout;
  logic        res_ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  cosine_vec_loader #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_rst_n(core_rst_n), .core_start(core_start),
    .core_a_vec(core_a_vec), .core_b_vec(core_b_vec),
    .core_done(core_done), .core_cos(core_cos),
    .res_valid(res_valid), .res_data(res_data), .res_timeout(res_timeout),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams 8 bytes (byte 0 in bits [7:0]) then walks CORE_RST and START.
  task automatic load_and_start(input logic [63:0] bytes, input string tag);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i*8 +: 8];
      step();
    end
    in_valid = 1'b0;
    chk({tag, "_a_vec"}, core_a_vec, bytes[31:0]);
    chk({tag, "_b_vec"}, core_b_vec, bytes[63:32]);
    chk({tag, "_rst_lo"}, core_rst_n, 1'b0);
    chk({tag, "_in_ready_rst"}, in_ready, 1'b0);
    chk({tag, "_start_lo"}, core_start, 1'b0);
    step();
    chk({tag, "_rst_hi"}, core_rst_n, 1'b1);
    chk({tag, "_start_hi"}, core_start, 1'b1);
    chk({tag, "_res_valid_ign"}, res_valid, 1'b0);
    step();
    chk({tag, "_start_pulse"}, core_start, 1'b0);
  endtask

  initial begin
    int wait_cycles;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    core_done = 1'b0; core_cos = 16'h0000; res_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_a_vec", core_a_vec, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_core_rst_n", core_rst_n, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Basic load and done-driven result
    load_and_start(64'h08070605_04030201, "t1");
    core_done = 1'b1; core_cos = 16'h0007; res_ready = 1'b1;
    step();
    chk("t1_res_valid", res_valid, 1'b1);
    chk("t1_res_data", res_data, 32'h0007);
    chk("t1_res_timeout", res_timeout, 1'b0);
    chk("t1_in_ready_res", in_ready, 1'b0);
    core_done = 1'b0;
    step();
    chk("t1_in_ready_after", in_ready, 1'b1);
    chk("t1_res_valid_drop", res_valid, 1'b0);
    chk("t1_a_vec_kept", core_a_vec, 32'h04030201);
    res_ready = 1'b0;

    // Timeout with done tied low, then backpressure on the result
    load_and_start(64'h18171615_14131211, "t2");
    wait_cycles = 0;
    while (!res_valid && wait_cycles < 200) begin
      wait_cycles++;
      step();
    end
    chk("t2_wait_cycles", wait_cycles, 32'd64);
    chk("t2_res_valid", res_valid, 1'b1);
    chk("t2_res_data", res_data, 32'h0);
    chk("t2_res_timeout", res_timeout, 1'b1);
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold_valid", res_valid, 1'b1);
      chk("t2_hold_data", res_data, 32'h0);
      chk("t2_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t2_a_vec_kept", core_a_vec, 32'h14131211);
    chk("t2_b_vec_kept", core_b_vec, 32'h18171615);
    chk("t2_back_idle", busy, 1'b0);

    // done arriving on the final WAIT cycle beats the timeout
    load_and_start(64'h38373635_34333231, "t3");
    for (int i = 0; i < 63; i++) step();
    chk("t3_not_yet", res_valid, 1'b0);
    core_done = 1'b1; core_cos = 16'hBEEF;
    step();
    core_done = 1'b0;
    chk("t3_res_valid", res_valid, 1'b1);
    chk("t3_res_timeout", res_timeout, 1'b0);
    chk("t3_res_data", res_data, 32'hBEEF);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset mid B load discards everything; done during load is ignored
    core_done = 1'b1; core_cos = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t4_busy_mid", busy, 1'b1);
    chk("t4_ign_done", res_valid, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t4_a_vec_clr", core_a_vec, 32'h0);
    chk("t4_b_vec_clr", core_b_vec, 32'h0);
    chk("t4_core_rst_n", core_rst_n, 1'b1);
    chk("t4_in_ready", in_ready, 1'b1);
    chk("t4_busy", busy, 1'b0);
    load_and_start(64'h28272625_24232221, "t4f");
    step();
    chk("t4f_res_valid", res_valid, 1'b1);
    chk("t4f_res_data", res_data, 32'h1234);
    core_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
